// File: rtl/cpu_int_pkg.sv
// Shared instruction-format constants for the interrupt feeder.
// Field map: opcode 31:27, rd 26:22, rs 21:17, imm 16:0.
package cpu_int_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int IMM_MSB = 16;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 17;

    localparam logic [4:0]  OPC_ADDI  = 5'b00101;
    localparam logic [31:0] NOP_INSTR = 32'd0;

    // rd = r0 + imm
    function automatic logic [31:0] encode_instr(
        input logic [4:0]       opc,
        input logic [4:0]       rd,
        input logic [IMM_W-1:0] imm
    );
        logic [31:0] instr;
        instr                  = NOP_INSTR;
        instr[OPC_MSB:OPC_LSB] = opc;
        instr[RD_MSB:RD_LSB]   = rd;
        instr[RS_MSB:RS_LSB]   = 5'd0;
        instr[IMM_MSB:IMM_LSB] = imm;
        return instr;
    endfunction

endpackage

// File: rtl/int_fifo.sv
// Event-code FIFO: storage, wrapping pointers, occupancy count.
// Ports: clock, reset, push, pop, wdata -> rdata (head), tail_data, count, full, empty.
module int_fifo
    import cpu_int_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [W-1:0]               tail_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // When full, wptr == rptr; a push+pop writes the slot being
    // vacated at the same edge, so the head read is still valid.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata     = r_mem[r_rptr];
    assign tail_data = r_mem[r_wptr - 1'b1];
    assign count     = r_count;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);

endmodule

// File: rtl/interrupt_queue.sv
// Buffers IO event codes and presents the head as an addi instruction
// (rd=INT_REG, rs=r0, imm=code) until acked; nop (0) when empty.
// Ports: clock, reset, evt_valid, evt_code, int_ack ->
//   interrupt_instruction, int_valid, count, overflow, drop_cnt.
// Build option: define INT_COALESCE_EN to drop a push equal to the
//   newest resident code.
module interrupt_queue
    import cpu_int_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter int         CODE_W     = 8,
    parameter logic [4:0] INT_OPCODE = OPC_ADDI,
    parameter logic [4:0] INT_REG    = 5'd27
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       evt_valid,
    input  logic [CODE_W-1:0]          evt_code,
    input  logic                       int_ack,
    output logic [31:0]                interrupt_instruction,
    output logic                       int_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

`ifdef INT_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_dup;
    logic [CODE_W-1:0] w_head;
    logic [CODE_W-1:0] w_tail;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    assign w_pop  = int_ack & ~w_empty;
    assign w_dup  = COALESCE & evt_valid & ~w_empty
                  & (evt_code == w_tail);
    // A full queue still accepts when the head leaves this cycle.
    assign w_push = evt_valid & ~w_dup & (~w_full | w_pop);
    assign w_drop = evt_valid & ~w_dup & w_full & ~w_pop;

    int_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .wdata     (evt_code),
        .rdata     (w_head),
        .tail_data (w_tail),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign int_valid = ~w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
    assign interrupt_instruction = int_valid
        ? encode_instr(INT_OPCODE, INT_REG, IMM_W'(w_head))
        : NOP_INSTR;

endmodule

// File: tb/tb_interrupt_queue.sv
// Self-checking bench for interrupt_queue: vector table, directed
// corner sequences, and random traffic against a queue-based model.
module tb_interrupt_queue;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        evt_valid;
    logic [7:0]  evt_code;
    logic        int_ack;
    logic [31:0] interrupt_instruction;
    logic        int_valid;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    interrupt_queue dut (
        .clock                 (clock),
        .reset                 (reset),
        .evt_valid             (evt_valid),
        .evt_code              (evt_code),
        .int_ack               (int_ack),
        .interrupt_instruction (interrupt_instruction),
        .int_valid             (int_valid),
        .count                 (count),
        .overflow              (overflow),
        .drop_cnt              (drop_cnt)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int q[$];
    bit m_ovf;
    int m_drop;
`ifdef INT_COALESCE_EN
    localparam bit CO = 1'b1;
`else
    localparam bit CO = 1'b0;
`endif

    typedef struct {
        bit          r;
        bit          v;
        int          c;
        bit          a;
        bit          ev;
        logic [31:0] ei;
        int          ecnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(int c);
        return 32'h2EC0_0000 + 32'(c);
    endfunction

    task automatic model(bit r, bit v, int c, bit a);
        bit pop;
        bit dup;
        if (r) begin
            q.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            pop = a && q.size() > 0;
            dup = CO && v && q.size() > 0 && q[$] == c;
            if (pop) void'(q.pop_front());
            if (v && !dup) begin
                if (q.size() < DEPTH) q.push_back(c);
                else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic step(bit r, bit v, int c, bit a);
        reset     = r;
        evt_valid = v;
        evt_code  = c[7:0];
        int_ack   = a;
        @(posedge clock);
        #1;
        model(r, v, c, a);
        reset     = 0;
        evt_valid = 0;
        int_ack   = 0;
    endtask

    task automatic check_model(string nm);
        logic [31:0] ei;
        ei = (q.size() > 0) ? enc(q[0]) : 32'd0;
        chk({nm, ".cnt"},   32'(count),     32'(q.size()));
        chk({nm, ".vld"},   32'(int_valid), 32'(q.size() > 0));
        chk({nm, ".instr"}, interrupt_instruction, ei);
        chk({nm, ".ovf"},   32'(overflow),  32'(m_ovf));
        chk({nm, ".drop"},  32'(drop_cnt),  32'(m_drop));
    endtask

    task automatic fill(int n, int base);
        for (int i = 0; i < n; i++) step(0, 1, base + i, 0);
    endtask

    initial begin
        reset = 1; evt_valid = 0; evt_code = 0; int_ack = 0;

        tbl.push_back('{1,0,0,0, 0,32'h0,0});
        tbl.push_back('{0,1,5,0, 1,32'h2EC00005,1});
        tbl.push_back('{0,0,0,1, 0,32'h0,0});
        tbl.push_back('{0,0,0,1, 0,32'h0,0});
        tbl.push_back('{0,1,1,0, 1,32'h2EC00001,1});
        tbl.push_back('{0,1,2,0, 1,32'h2EC00001,2});
        tbl.push_back('{0,1,3,0, 1,32'h2EC00001,3});
        tbl.push_back('{0,0,0,1, 1,32'h2EC00002,2});
        tbl.push_back('{0,0,0,1, 1,32'h2EC00003,1});
        tbl.push_back('{0,0,0,1, 0,32'h0,0});
        tbl.push_back('{0,1,6,0, 1,32'h2EC00006,1});
        tbl.push_back('{0,1,7,1, 1,32'h2EC00007,1});
        tbl.push_back('{0,0,0,1, 0,32'h0,0});
        tbl.push_back('{0,1,8,1, 1,32'h2EC00008,1});
        tbl.push_back('{0,0,0,1, 0,32'h0,0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].a);
            chk($sformatf("vec%0d.vld", i), 32'(int_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.ins", i), interrupt_instruction, tbl[i].ei);
            chk($sformatf("vec%0d.cnt", i), 32'(count), 32'(tbl[i].ecnt));
        end

        // overflow: fill, push two more, drain in order
        step(1, 0, 0, 0);
        fill(8, 1);
        step(0, 1, 20, 0);
        step(0, 1, 21, 0);
        chk("ovf.cnt",  32'(count), 32'd8);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.drop", 32'(drop_cnt), 32'd2);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d", i), interrupt_instruction, enc(i));
            step(0, 0, 0, 1);
        end
        chk("drain.empty", interrupt_instruction, 32'd0);
        chk("drain.ovf",   32'(overflow), 32'd1);

        // full with simultaneous push and ack
        step(1, 0, 0, 0);
        fill(8, 1);
        step(0, 1, 9, 1);
        chk("fpp.cnt", 32'(count), 32'd8);
        chk("fpp.ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("fpp.drain%0d", i), interrupt_instruction, enc(i));
            step(0, 0, 0, 1);
        end
        chk("fpp.end", 32'(int_valid), 32'd0);

        // reset mid-stream with a push
        fill(5, 40);
        step(1, 1, 30, 0);
        chk("rst.cnt",   32'(count), 32'd0);
        chk("rst.vld",   32'(int_valid), 32'd0);
        chk("rst.instr", interrupt_instruction, 32'd0);

        // duplicates
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        step(0, 1, 7, 0);
        chk("co.cnt", 32'(count), CO ? 32'd2 : 32'd4);
        chk("co.h0", interrupt_instruction, enc(4));
        step(0, 0, 0, 1);
        chk("co.h1", interrupt_instruction, CO ? enc(7) : enc(4));

        // drop counter saturation
        step(1, 0, 0, 0);
        fill(8, 100);
        for (int i = 0; i < 260; i++) step(0, 1, 200 + (i % 50), 0);
        chk("sat.drop", 32'(drop_cnt), 32'd255);
        chk("sat.cnt",  32'(count), 32'd8);

        // random traffic vs model
        step(1, 0, 0, 0);
        check_model("rnd.rst");
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit a;
            int c;
            v = ($urandom_range(0, 99) < 60);
            a = ($urandom_range(0, 99) < ((i / 500) % 2 ? 25 : 55));
            c = $urandom_range(0, 3) + (($urandom_range(0, 3) == 0) ? 250 : 0);
            step($urandom_range(0, 999) == 0, v, c, a);
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
